// File: rtl/pipe_cond_sum_adder_pkg.sv
// Shared definitions for the pipelined conditional-sum adder: op encoding,
// result flag bundle and segment sizing helpers.
package pipe_cond_sum_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

    function automatic int calc_nseg(input int width, input int seg);
        return width / seg;
    endfunction

    // Width must split evenly into at least two segments.
    function automatic bit cfg_ok(input int width, input int seg);
        return (seg > 0) && (width % seg == 0) && (width / seg >= 2) &&
               (width >= 8) && (width <= 64);
    endfunction

endpackage

// File: rtl/pipe_cond_sum_adder_cond_seg_sum.sv
// One SEG-bit conditional-sum segment: sum and carry-out precomputed for
// both possible carry-in values.
module cond_seg_sum #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    output logic [SEG-1:0] sum0,
    output logic           cout0,
    output logic [SEG-1:0] sum1,
    output logic           cout1
);

    assign {cout0, sum0} = {1'b0, a} + {1'b0, b};
    assign {cout1, sum1} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, 1'b1};

endmodule

// File: rtl/pipe_cond_sum_adder.sv
// Two-stage pipelined conditional-sum adder/subtractor with valid/ready on both sides.
// Optional signed saturation of overflowing results: define PIPE_COND_SUM_SAT_EN.
module pipe_cond_sum_adder
    import pipe_cond_sum_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NSEG = calc_nseg(WIDTH, SEG);

    if (!cfg_ok(WIDTH, SEG)) begin : g_cfg_err
        $error("pipe_cond_sum_adder: WIDTH must be a multiple of SEG with at least 2 segments");
    end

    logic               s1_v, s2_v, s1_load, s2_load;
    logic [WIDTH-1:0]   b_eff, a_sum0;
    logic [WIDTH-1:SEG] a_sum1;
    logic [NSEG-1:1]    a_cout0, a_cout1;
    logic               c0, a_cmsb0, a_cmsb1;
    logic [SEG:0]       seg0_full;

    logic [WIDTH-1:0]   s1_sum0;
    logic [WIDTH-1:SEG] s1_sum1;
    logic [NSEG-1:1]    s1_cout0, s1_cout1;
    logic               s1_c_seg0, s1_cmsb0, s1_cmsb1;

    logic [WIDTH-1:0]   b_sum, res, s2_sum;
    logic               carry, cmsb;
    flags_t             b_flags, s2_flags;

    assign s2_load  = !s2_v || out_ready;
    assign s1_load  = !s1_v || s2_load;
    assign in_ready = s1_load;

    assign b_eff = (in_sub == OP_SUB) ? ~in_b : in_b;
    assign c0    = (in_sub == OP_SUB) ? 1'b1 : in_cin;

    // Segment 0 sees the real carry-in, so it needs only one adder.
    assign seg0_full          = {1'b0, in_a[SEG-1:0]} + {1'b0, b_eff[SEG-1:0]} + {{SEG{1'b0}}, c0};
    assign a_sum0[SEG-1:0]    = seg0_full[SEG-1:0];

    for (genvar i = 1; i < NSEG; i++) begin : g_seg
        cond_seg_sum #(.SEG(SEG)) u_seg (
            .a     (in_a[i*SEG +: SEG]),
            .b     (b_eff[i*SEG +: SEG]),
            .sum0  (a_sum0[i*SEG +: SEG]),
            .cout0 (a_cout0[i]),
            .sum1  (a_sum1[i*SEG +: SEG]),
            .cout1 (a_cout1[i])
        );
    end

    // Carry into the MSB recovered from the MSB sum bit under each assumption.
    assign a_cmsb0 = in_a[WIDTH-1] ^ b_eff[WIDTH-1] ^ a_sum0[WIDTH-1];
    assign a_cmsb1 = in_a[WIDTH-1] ^ b_eff[WIDTH-1] ^ a_sum1[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s1_sum0   <= '0;
            s1_sum1   <= '0;
            s1_cout0  <= '0;
            s1_cout1  <= '0;
            s1_c_seg0 <= 1'b0;
            s1_cmsb0  <= 1'b0;
            s1_cmsb1  <= 1'b0;
        end else if (s1_load) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_sum0   <= a_sum0;
                s1_sum1   <= a_sum1;
                s1_cout0  <= a_cout0;
                s1_cout1  <= a_cout1;
                s1_c_seg0 <= seg0_full[SEG];
                s1_cmsb0  <= a_cmsb0;
                s1_cmsb1  <= a_cmsb1;
            end
        end
    end

`ifdef PIPE_COND_SUM_SAT_EN
    logic s1_a_sign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_sign <= 1'b0;
        end else if (s1_load && in_valid) begin
            s1_a_sign <= in_a[WIDTH-1];
        end
    end
`endif

    // Ripple the resolved carry up through the segment selects.
    always_comb begin
        carry = s1_c_seg0;
        res   = s1_sum0;
        cmsb  = 1'b0;
        for (int i = 1; i < NSEG; i++) begin
            if (carry) begin
                res[i*SEG +: SEG] = s1_sum1[i*SEG +: SEG];
            end
            if (i == NSEG - 1) begin
                cmsb = carry ? s1_cmsb1 : s1_cmsb0;
            end
            carry = carry ? s1_cout1[i] : s1_cout0[i];
        end
        b_flags.cout = carry;
        b_flags.ovf  = cmsb ^ carry;
        b_sum        = res;
`ifdef PIPE_COND_SUM_SAT_EN
        if (b_flags.ovf) begin
            b_sum = s1_a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        b_flags.zero = (b_sum == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v     <= 1'b0;
            s2_sum   <= '0;
            s2_flags <= '0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_sum   <= b_sum;
                s2_flags <= b_flags;
            end
        end
    end

    assign out_valid = s2_v;
    assign out_sum   = s2_sum;
    assign out_cout  = s2_flags.cout;
    assign out_ovf   = s2_flags.ovf;
    assign out_zero  = s2_flags.zero;

endmodule

// File: tb/tb_pipe_cond_sum_adder.sv
// Self-checking bench for pipe_cond_sum_adder: directed vector table, backpressure,
// async reset and a random stream checked by a FIFO scoreboard.
module tb_pipe_cond_sum_adder;
    import pipe_cond_sum_adder_pkg::*;

    localparam int WIDTH = 32;
    localparam int SEG   = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_cin = 1'b0;
    logic             in_sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout, out_ovf, out_zero;

    always #5 clk = ~clk;

    pipe_cond_sum_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    typedef struct {
        logic [31:0] sum;
        flags_t      flags;
    } result_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          pushes = 0;
    int          pops = 0;
    result_t     exp_q[$];
    vec_t        vecs[10];
    logic        held = 1'b0;
    logic [31:0] held_sum;
    logic [2:0]  held_flags;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    function automatic result_t model(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        result_t     r;
        logic [31:0] bb;
        logic [32:0] full;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
        r.sum        = full[31:0];
        r.flags.cout = full[32];
        r.flags.ovf  = (a[31] == bb[31]) && (r.sum[31] != a[31]);
`ifdef PIPE_COND_SUM_SAT_EN
        if (r.flags.ovf) r.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        r.flags.zero = (r.sum == 32'd0);
        return r;
    endfunction

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        bit acc = 1'b0;
        int t = 0;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        if (!acc) check_output("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_output("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: pushes on accepted beats, pops on delivered results, checks stall stability.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check_output("stall_valid", 64'(out_valid), 64'd1);
                check_output("stall_sum", 64'(out_sum), 64'(held_sum));
                check_output("stall_flags", 64'({out_cout, out_ovf, out_zero}), 64'(held_flags));
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
                pushes++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("sb_unexpected_output", 64'd1, 64'd0);
                end else begin
                    result_t r;
                    r = exp_q.pop_front();
                    check_output("sb_sum", 64'(out_sum), 64'(r.sum));
                    check_output("sb_flags", 64'({out_cout, out_ovf, out_zero}), 64'(r.flags));
                end
                pops++;
            end
            held       = out_valid && !out_ready;
            held_sum   = out_sum;
            held_flags = {out_cout, out_ovf, out_zero};
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          p0, q0;
        bit          done;
        result_t     rx;
        logic [31:0] ra, rb;

        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0};
`ifdef PIPE_COND_SUM_SAT_EN
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
`else
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
`endif

        // Asynchronous reset with no clock edge in between.
        #1 rst_n = 1'b0;
        #1;
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_out_sum", 64'(out_sum), 64'd0);
        check_output("rst_flags", 64'({out_cout, out_ovf, out_zero}), 64'd0);
        #10 rst_n = 1'b1;
        #1;
        check_output("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed table with latency checks.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            @(negedge clk);
            check_output($sformatf("vec%0d_lat_early", i), 64'(out_valid), 64'd0);
            @(negedge clk);
            check_output($sformatf("vec%0d_lat_valid", i), 64'(out_valid), 64'd1);
            check_output($sformatf("vec%0d_sum", i), 64'(out_sum), 64'(vecs[i].sum));
            check_output($sformatf("vec%0d_cout", i), 64'(out_cout), 64'(vecs[i].cout));
            check_output($sformatf("vec%0d_ovf", i), 64'(out_ovf), 64'(vecs[i].ovf));
            check_output($sformatf("vec%0d_zero", i), 64'(out_zero), 64'(vecs[i].zero));
            @(posedge clk);
            #1;
        end
        wait_drain();

        // Backpressure: two beats fill the pipe, the third must wait.
        out_ready = 1'b0;
        q0 = pops;
        apply_stimulus(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        apply_stimulus(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1);
        in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("bp_in_ready_low", 64'(in_ready), 64'd0);
            check_output("bp_hold_valid", 64'(out_valid), 64'd1);
            check_output("bp_hold_sum", 64'(out_sum), 64'h3);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge clk);
        check_output("bp_stream_second", 64'(out_sum), 64'h0000_00FF);
        @(negedge clk);
        check_output("bp_stream_third", 64'(out_sum), 64'hFFFF_FFFE);
        check_output("bp_stream_third_cout", 64'(out_cout), 64'd1);
        @(posedge clk);
        #1;
        wait_drain();
        check_output("bp_delivered", 64'(pops - q0), 64'd3);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        apply_stimulus(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0);
        apply_stimulus(32'h0000_0033, 32'h0000_0044, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("midrst_out_valid", 64'(out_valid), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check_output("midrst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        q0 = pops;
        apply_stimulus(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b1);
        wait_drain();
        check_output("midrst_delivered", 64'(pops - q0), 64'd1);

        // Random stream with random gaps and random backpressure.
        p0 = pushes;
        q0 = pops;
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 150; k++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    ra = rand_operand();
                    rb = rand_operand();
                    apply_stimulus(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        check_output("rand_accepted", 64'(pushes - p0), 64'd150);
        check_output("rand_delivered", 64'(pops - q0), 64'd150);

        rx = model(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        check_output("model_vs_table", 64'(rx.sum), 64'(vecs[2].sum));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
